// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions used by fetch and decode.
package rv_pkg;

    // addi x0, x0, 0: the canonical bubble shared by fetch and the decode flush path
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FETCH_DEPTH_DEFAULT = 2;

    // One buffered fetch result: the instruction word and the address it came from
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Sequential PC step; wraps naturally at the top of the address space
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {instruction, pc} pairs waiting for decode.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    // Pointers wrap at DEPTH so non-power-of-two depths also work
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Pointer/count bookkeeping; clear drops everything held (used on redirect)
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= bump(r_wrPtr);
            end
            if (i_pop) begin
                r_rdPtr <= bump(r_rdPtr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (!rst && !i_clear && i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues credit-limited imem requests,
// buffers responses and drives the IF/ID register consumed by decode.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = FETCH_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_addr,
    output logic                valid_out,
    output logic [31:0]         instruction_out,
    output logic [31:0]         pre_address_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_pcQueue [DEPTH];
    logic [PW-1:0] r_pqHead;
    logic [PW-1:0] r_pqTail;

    logic          w_pop;
    logic          w_push;
    logic          w_req;
    logic          w_accept;
    logic [SW-1:0] w_occupancy;
    logic [CW-1:0] w_fifoCount;
    logic          w_fifoFull;
    fetch_entry_t  w_pushData;
    fetch_entry_t  w_head;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Decode takes the head whenever it is not stalled and no flush is happening
    assign w_pop = !stall && (w_fifoCount != '0) && !redirect;

    // Credit rule: buffered + in-flight words (after this cycle's pop) stay below DEPTH,
    // so every response is guaranteed a FIFO slot
    assign w_occupancy = SW'(w_fifoCount) + SW'(r_outstanding) - SW'(w_pop);
    assign w_req       = !rst && !redirect && (w_occupancy < SW'(DEPTH));
    assign w_accept    = w_req && imem.imem_ready;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    // Responses belonging to a flushed path are swallowed while drop is non-zero
    assign w_push = imem.imem_rvalid && (r_drop == '0) && !redirect;

    assign w_pushData.instr = imem.imem_rdata;
    assign w_pushData.pc    = r_pcQueue[r_pqHead];

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect),
        .i_data  (w_pushData),
        .o_head  (w_head),
        .o_count (w_fifoCount),
        .o_full  (w_fifoFull)
    );

    // PC, in-flight PC queue, outstanding and drop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_pqHead      <= '0;
            r_pqTail      <= '0;
        end else begin
            if (redirect) begin
                r_pc <= redirect_addr;
            end else if (w_accept) begin
                r_pc <= next_pc(r_pc);
            end

            if (w_accept) begin
                r_pcQueue[r_pqTail] <= r_pc;
                r_pqTail            <= bump(r_pqTail);
            end
            if (imem.imem_rvalid) begin
                r_pqHead <= bump(r_pqHead);
            end

            case ({w_accept, imem.imem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect) begin
                r_drop <= r_outstanding - CW'(imem.imem_rvalid);
            end else if (imem.imem_rvalid && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
        end
    end

    // IF/ID register: redirect flushes, stall freezes, otherwise take head or a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out       <= 1'b0;
            instruction_out <= NOP_INSTR;
            pre_address_out <= '0;
        end else if (redirect) begin
            valid_out       <= 1'b0;
            instruction_out <= NOP_INSTR;
        end else if (!stall) begin
            if (w_pop) begin
                valid_out       <= 1'b1;
                instruction_out <= w_head.instr;
                pre_address_out <= w_head.pc;
            end else begin
                valid_out       <= 1'b0;
                instruction_out <= NOP_INSTR;
            end
        end
    end

    // A response arriving with the buffer full would mean the credit rule is broken
    assert property (@(posedge clk) disable iff (rst) !(w_push && w_fifoFull));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests with a known
// word per address, stimulus queues the expected PC stream, and a monitor checks
// every instruction that enters IF/ID.
module tb_fetch_unit;
    import rv_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memTxn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        valid_out;
    logic [31:0] instruction_out;
    logic [31:0] pre_address_out;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expQ [$];
    memTxn_t     memQ [$];
    int          cyc        = 0;
    int          lastDue    = 0;
    int          memLat     = 1;
    bit          memRandLat = 1'b0;
    bit          memToggle  = 1'b0;

    fetch_unit_if imemBus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imemBus),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_addr   (redirect_addr),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pre_address_out (pre_address_out)
    );

    always #5 clk = ~clk;

    // Every address returns a distinct, recognisable word
    function automatic logic [31:0] wordFor(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0003;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [31:0] a);
        @(negedge clk);
        rst           = r;
        stall         = s;
        redirect      = rd;
        redirect_addr = a;
    endtask

    task automatic pushRun(input logic [31:0] startPc, input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(startPc + 32'(4 * i));
        end
    endtask

    // Run until every expected instruction has been seen, then freeze IF/ID with stall
    task automatic waitDrain(input bit randomStall);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                stall = 1'b1;
                done  = 1'b1;
            end else if (randomStall) begin
                stall = ($urandom_range(3, 0) == 0);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d_pending expected=0_pending", expQ.size());
            expQ.delete();
            stall = 1'b1;
        end
    endtask

    // Memory model: in-order responses, per-request latency, optional ready toggling
    initial begin
        imemBus.imem_ready  = 1'b1;
        imemBus.imem_rvalid = 1'b0;
        imemBus.imem_rdata  = '0;
        forever begin
            logic        acc;
            logic        rstSeen;
            logic [31:0] a;
            int          lat;
            int          due;
            @(negedge clk);
            #4;
            acc     = imemBus.imem_req && imemBus.imem_ready;
            a       = imemBus.imem_addr;
            rstSeen = rst;
            @(posedge clk);
            cyc++;
            if (rstSeen) begin
                memQ.delete();
                lastDue = cyc;
            end else begin
                if (imemBus.imem_rvalid && memQ.size() > 0) begin
                    void'(memQ.pop_front());
                end
                if (acc) begin
                    lat = memRandLat ? int'($urandom_range(3, 1)) : memLat;
                    due = cyc + lat;
                    if (due <= lastDue) begin
                        due = lastDue + 1;
                    end
                    lastDue = due;
                    memQ.push_back('{addr: a, due: due});
                end
            end
            #1;
            if (memQ.size() > 0 && memQ[0].due <= cyc + 1) begin
                imemBus.imem_rvalid = 1'b1;
                imemBus.imem_rdata  = wordFor(memQ[0].addr);
            end else begin
                imemBus.imem_rvalid = 1'b0;
                imemBus.imem_rdata  = '0;
            end
            imemBus.imem_ready = memToggle ? ~imemBus.imem_ready : 1'b1;
        end
    end

    // Monitor: every newly loaded valid IF/ID entry must match the scoreboard head
    initial begin
        forever begin
            logic        sStall;
            logic        sRedir;
            logic        sRst;
            logic [31:0] e;
            @(posedge clk);
            sStall = stall;
            sRedir = redirect;
            sRst   = rst;
            #1;
            if (!sRst && !sRedir && !sStall && valid_out) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_instr actual_pc=%h expected=none", pre_address_out);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ifid_pc", pre_address_out, e);
                    checkOutput("ifid_instr", instruction_out, wordFor(e));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_instr", instruction_out, 32'h0000_0013);
        checkOutput("rst_pc", pre_address_out, 32'h0);
        checkOutput("rst_req", 32'(imemBus.imem_req), 32'd0);

        $display("[TB] streaming from reset, L=1");
        pushRun(32'h0, 3);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("first_valid_edge2", 32'(valid_out), 32'd0);
        @(negedge clk);
        checkOutput("first_valid_edge3", 32'(valid_out), 32'd1);
        waitDrain(1'b0);

        $display("[TB] stall for 4 cycles on pc 0x8");
        pushRun(32'hC, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_hold_pc", pre_address_out, 32'h8);
        end
        checkOutput("stall_hold_valid", 32'(valid_out), 32'd1);
        checkOutput("stall_req_low", 32'(imemBus.imem_req), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        checkOutput("release_pc_c", pre_address_out, 32'hC);
        @(negedge clk);
        checkOutput("release_pc_10", pre_address_out, 32'h10);
        waitDrain(1'b0);

        $display("[TB] redirect+stall together, then redirect with 2 in flight (L=3)");
        memLat = 3;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rs_valid", 32'(valid_out), 32'd0);
        checkOutput("rs_instr", instruction_out, 32'h0000_0013);
        checkOutput("rs_pc_hold", pre_address_out, 32'h18);
        checkOutput("rs_newpc", imemBus.imem_addr, 32'h40);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        @(negedge clk);
        checkOutput("inflight_req_low", 32'(imemBus.imem_req), 32'd0);
        checkOutput("flush_valid", 32'(valid_out), 32'd0);
        checkOutput("flush_instr", instruction_out, 32'h0000_0013);
        checkOutput("flush_newpc", imemBus.imem_addr, 32'h100);
        redirect = 1'b0;
        pushRun(32'h100, 4);
        waitDrain(1'b0);

        $display("[TB] redirect to top of address space, wrap");
        memLat = 1;
        pushRun(32'hFFFF_FFFC, 4);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_newpc", imemBus.imem_addr, 32'hFFFF_FFFC);
        waitDrain(1'b0);

        $display("[TB] ready toggling, random latency, random stall");
        memRandLat = 1'b1;
        memToggle  = 1'b1;
        pushRun(32'h200, 16);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        waitDrain(1'b1);
        memRandLat = 1'b0;
        memToggle  = 1'b0;

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("midrst_valid", 32'(valid_out), 32'd0);
        checkOutput("midrst_instr", instruction_out, 32'h0000_0013);
        checkOutput("midrst_pc", pre_address_out, 32'h0);
        checkOutput("midrst_addr", imemBus.imem_addr, 32'h0);
        checkOutput("midrst_req", 32'(imemBus.imem_req), 32'd0);
        pushRun(32'h0, 4);
        rst = 1'b0;
        waitDrain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode stage. It owns the PC, issues in-order requests to instruction memory through a valid/ready handshake and buffers returned words in a small FIFO. It drives the IF/ID register (instruction plus its PC) that decode consumes, honouring stall from hazard logic and redirect from branch/jalr resolution.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- DEPTH, 2, fetch FIFO entries; also the maximum number of in-flight plus buffered words
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  request valid
- imem_addr  output  32  request address = PC
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  response valid; in order, latency ≥1 cycle after acceptance
- imem_rdata  input  32  response instruction word
- stall  input  1  hold IF/ID register (decode cannot accept)
- redirect  input  1  taken branch/jalr; flush the fetch path
- redirect_addr  input  32  new PC
- valid_out  output  1  IF/ID holds a real instruction
- instruction_out  output  32  IF/ID instruction; NOP 32'h00000013 when invalid
- pre_address_out  output  32  IF/ID PC of instruction_out

## Operation
- State: pc, FIFO (count 0..DEPTH), outstanding counter (0..DEPTH), drop counter (0..DEPTH), IF/ID register.
- Reset: pc=RESET_PC; count=outstanding=drop=0; valid_out=0, instruction_out=32'h00000013, pre_address_out=0; imem_req=0 while rst high.
- pop = !stall && count>0 && !redirect.
- imem_req = !rst && !redirect && (count + outstanding − pop) < DEPTH; combinational from state.
- Acceptance (imem_req && imem_ready): outstanding++, pc += 4 (mod 2^32, wraps 0xFFFF_FFFC→0). Each FIFO entry stores {word, pc}, with the pc captured in a parallel in-flight PC queue.
- Response: if drop>0, discard word and drop--; else push {imem_rdata, PC} into FIFO. Either way, outstanding--.
- Accept and response in the same cycle: outstanding is unchanged.
- IF/ID update when !stall: if pop, load head (valid_out=1); else load bubble (valid_out=0, NOP, pre_address_out holds). When stall is high, IF/ID holds.
- Redirect (priority over stall and everything else): pc<=redirect_addr; FIFO cleared; IF/ID <= bubble; drop <= outstanding minus any response arriving this cycle, which is itself discarded; outstanding is updated normally; no request issued this cycle.
- Redirect while drop>0: drop is recomputed as above; it does not accumulate beyond outstanding.
- redirect_addr is not alignment-checked; bits [1:0] pass through.
- Response while FIFO full: this cannot occur under the credit rule. Assert it in simulation.

## Timing
- Request accepted at edge N, response at N+L (L≥1): word enters FIFO at edge N+L and appears on IF/ID at edge N+L+1 if not stalled.
- With L=1, imem_ready=1, no stall: sustained 1 instruction/cycle. After reset, the first valid_out appears at the 3rd rising edge after rst falls.
- Redirect asserted at edge R: IF/ID is a bubble after R; first request to redirect_addr at cycle R+1; with L=1, the first valid instruction from the new path appears after edge R+3.
- Stall held k cycles: IF/ID is frozen k cycles, FIFO fills to DEPTH, then imem_req drops. No word is lost or duplicated.
- Reset asserted mid-operation: all state returns to reset values at that edge. In-flight responses still arriving must be ignored: drop is loaded with outstanding at reset only if the memory is not also reset. Memory shares rst, so drop=0.

## Structure
- Shared package rv_pkg holds NOP_INSTR = 32'h00000013 and RESET_PC_DEFAULT. The decode pipe's flush NOP uses the same constant.
- One sub-module: fetch_fifo (DEPTH-entry synchronous FIFO of {instr[31:0], pc[31:0]} with push, pop, clear, count). PC queue and counters live in fetch_unit.

## Test plan
- Reset, then memory L=1, ready=1: requests 0x0,0x4,0x8…; IF/ID shows pc 0x0,0x4,0x8 on consecutive cycles, valid_out=1 from the 3rd edge.
- stall high 4 cycles mid-stream: IF/ID frozen on pc 0x8; imem_req low once count+outstanding=2; after release, 0xC,0x10 follow with no gap or duplicate.
- redirect to 0x100 with 2 words in flight (L=3): both are discarded, IF/ID is a bubble (NOP, valid 0), and the next valid pre_address_out is 0x100.
- redirect and stall in the same cycle: redirect wins; the bubble is loaded and pc=redirect_addr.
- imem_ready toggling 1/0 with random L in 1..3: the output PC sequence is strictly +4 and the FIFO-overflow assertion never fires.
- redirect to 0xFFFF_FFFC: the next fetch wraps to 0x0000_0000.
